// File: rtl/calc_fmt_pkg.sv
// calc_fmt_pkg: state codes and ASCII constants shared by the result formatter.
//   ST_*    : formatter FSM state codes (IDLE, CONV, SIGN, DIGIT, CR, LF)
//   ASCII_* : bytes emitted toward the UART ('-', '0', CR, LF)
package calc_fmt_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_CONV  = 3'd1;
  localparam logic [ST_W-1:0] ST_SIGN  = 3'd2;
  localparam logic [ST_W-1:0] ST_DIGIT = 3'd3;
  localparam logic [ST_W-1:0] ST_CR    = 3'd4;
  localparam logic [ST_W-1:0] ST_LF    = 3'd5;

  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: iterative double-dabble converter, one bit per cycle.
//   clk, rst : clock and synchronous active-high reset
//   start    : load bin and begin a BIN_W-cycle conversion
//   bin      : unsigned binary input, sampled on start
//   done     : one-cycle pulse, bcd valid from this cycle until next start
//   bcd      : DIG_N packed BCD digits, digit 0 in bcd[3:0]
module bin2bcd #(
  parameter int unsigned BIN_W = 32,
  parameter int unsigned DIG_N = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               done,
  output logic [DIG_N*4-1:0] bcd
);

  localparam int unsigned BCD_W = DIG_N * 4;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [BCD_W-1:0] adj_c;

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    adj_c = bcd;
    for (int i = 0; i < int'(DIG_N); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        bcd <= {adj_c[BCD_W-2:0], sh[BIN_W-1]};
        sh  <= {sh[BIN_W-2:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/res_formatter.sv
// res_formatter: turns a signed ALU result into an ASCII decimal line for a UART.
//   clk, n_rst        : clock and synchronous active-high reset
//   alu_done/calc_res : result strobe and signed result
//   tx_data/tx_valid  : byte stream out, held until tx_ready accepts it
//   tx_ready          : UART accepts the presented byte this cycle
//   busy              : formatter is not idle
//   drop              : one-cycle pulse after a result arrived while busy
// Build option: define FMT_CRLF_EN to terminate lines with CR LF instead of LF.
module res_formatter
  import calc_fmt_pkg::*;
#(
  parameter int unsigned RES_W = 32,
  parameter int unsigned DIG_N = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             alu_done,
  input  logic [RES_W-1:0] calc_res,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             drop
);

  localparam int unsigned BCD_W = DIG_N * 4;
  localparam int unsigned IDX_W = $clog2(DIG_N);

  logic [ST_W-1:0]  state, state_nxt;
  logic             neg, neg_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             start_c;
  logic [RES_W-1:0] mag_c;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [IDX_W-1:0] msd_c;

  // Two's-complement negate; 0x80000000 maps to itself, which is correct unsigned.
  assign mag_c = calc_res[RES_W-1] ? -calc_res : calc_res;

  function automatic logic [7:0] dig_char(input logic [BCD_W-1:0] b,
                                          input logic [IDX_W-1:0] i);
    return ASCII_ZERO + 8'(4'(b >> {i, 2'b00}));
  endfunction

  // Index of the most significant non-zero digit; 0 for a zero result.
  always_comb begin
    msd_c = '0;
    for (int i = 0; i < int'(DIG_N); i++) begin
      if (bcd[i*4 +: 4] != 4'd0) msd_c = IDX_W'(i);
    end
  end

  bin2bcd #(
    .BIN_W (RES_W),
    .DIG_N (DIG_N)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (n_rst),
    .start (start_c),
    .bin   (mag_c),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Next state and next registered outputs; the next byte is prepared on each accept.
  always_comb begin
    state_nxt = state;
    neg_nxt   = neg;
    idx_nxt   = idx;
    valid_nxt = tx_valid;
    data_nxt  = tx_data;
    start_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (alu_done) begin
          start_c   = 1'b1;
          neg_nxt   = calc_res[RES_W-1];
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          idx_nxt   = msd_c;
          valid_nxt = 1'b1;
          if (neg) begin
            state_nxt = ST_SIGN;
            data_nxt  = ASCII_MINUS;
          end else begin
            state_nxt = ST_DIGIT;
            data_nxt  = dig_char(bcd, msd_c);
          end
        end
      end
      ST_SIGN: begin
        if (tx_ready) begin
          state_nxt = ST_DIGIT;
          data_nxt  = dig_char(bcd, idx);
        end
      end
      ST_DIGIT: begin
        if (tx_ready) begin
          if (idx == '0) begin
`ifdef FMT_CRLF_EN
            state_nxt = ST_CR;
            data_nxt  = ASCII_CR;
`else
            state_nxt = ST_LF;
            data_nxt  = ASCII_LF;
`endif
          end else begin
            idx_nxt  = idx - IDX_W'(1);
            data_nxt = dig_char(bcd, idx - IDX_W'(1));
          end
        end
      end
      ST_CR: begin
        if (tx_ready) begin
          state_nxt = ST_LF;
          data_nxt  = ASCII_LF;
        end
      end
      ST_LF: begin
        if (tx_ready) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
          data_nxt  = 8'h00;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
        data_nxt  = 8'h00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= ST_IDLE;
      neg      <= 1'b0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_nxt;
      neg      <= neg_nxt;
      idx      <= idx_nxt;
      tx_valid <= valid_nxt;
      tx_data  <= data_nxt;
      busy     <= (state_nxt != ST_IDLE);
      drop     <= alu_done && (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_res_formatter.sv
// tb_res_formatter: directed bench for res_formatter (table of results plus
// hand-written stall, drop and reset sequences). Honours FMT_CRLF_EN.
module tb_res_formatter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        alu_done = 1'b0;
  logic [31:0] calc_res = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        drop;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [31:0] val;
    logic [87:0] txt;
    logic [3:0]  len;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  res_formatter dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .alu_done (alu_done),
    .calc_res (calc_res),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] ch(input vec_t v, input int i);
    logic [87:0] t;
    t = v.txt;
    return t[(int'(v.len) - 1 - i) * 8 +: 8];
  endfunction

  // Check the terminator bytes with tx_ready=1; optionally strobe alu_done during LF.
  task automatic check_term(input string tag, input bit done_at_lf);
`ifdef FMT_CRLF_EN
    check({tag, " cr"}, 32'({tx_valid, tx_data}), 32'({1'b1, 8'h0D}));
    tick();
`endif
    check({tag, " lf"}, 32'({tx_valid, tx_data}), 32'({1'b1, 8'h0A}));
    if (done_at_lf) alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check({tag, " end"}, 32'({busy, tx_valid, drop}), 32'({2'b00, done_at_lf}));
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit done_at_lf);
    int cyc;
    tx_ready = 1'b1;
    calc_res = v.val;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd33);
    for (int i = 0; i < int'(v.len); i++) begin
      check({tag, " byte"}, 32'({tx_valid, tx_data}), 32'({1'b1, ch(v, i)}));
      tick();
    end
    check_term(tag, done_at_lf);
  endtask

  initial begin
    logic [7:0] got [$];
    logic [7:0] exp_b [4];
    int         exp_n;
    bit         prev_stall;
    logic [7:0] prev_data;
    int         cyc;
    int         cnt;

    vecs[0] = '{val: 32'h0000_007B, txt: 88'("123"),         len: 4'd3};
    vecs[1] = '{val: 32'h8000_0000, txt: 88'("-2147483648"), len: 4'd11};
    vecs[2] = '{val: 32'h0000_0000, txt: 88'("0"),           len: 4'd1};
    vecs[3] = '{val: 32'hFFFF_FFFF, txt: 88'("-1"),          len: 4'd2};
    vecs[4] = '{val: 32'h7FFF_FFFF, txt: 88'("2147483647"),  len: 4'd10};
    vecs[5] = '{val: 32'hFFFF_FF85, txt: 88'("-123"),        len: 4'd4};
    vecs[6] = '{val: 32'h0000_000A, txt: 88'("10"),          len: 4'd2};
    vecs[7] = '{val: 32'h3B9A_CA00, txt: 88'("1000000000"),  len: 4'd10};
    vecs[8] = '{val: 32'h0000_0009, txt: 88'("9"),           len: 4'd1};

    // Reset state
    n_rst = 1'b1;
    tick();
    tick();
    check("reset outputs", 32'({tx_valid, tx_data, busy, drop}), 32'd0);
    n_rst = 1'b0;
    tick();

    // Table-driven results, one alu_done landing on the LF accept cycle
    for (int k = 0; k < NV; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k), k == 4);
      tick();
    end

    // -1 with tx_ready toggling: bytes stable while stalled, none lost or repeated
    exp_b[0] = 8'h2D;
    exp_b[1] = 8'h31;
`ifdef FMT_CRLF_EN
    exp_b[2] = 8'h0D;
    exp_b[3] = 8'h0A;
    exp_n = 4;
`else
    exp_b[2] = 8'h0A;
    exp_b[3] = 8'h00;
    exp_n = 3;
`endif
    tx_ready = 1'b0;
    calc_res = 32'hFFFF_FFFF;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("stall latency", 32'(cyc), 32'd33);
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int c = 0; c < 60; c++) begin
      if (prev_stall) check("stall hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
      tx_ready = c[0];
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      tick();
      if (!busy) break;
    end
    check("stall count", 32'(got.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < got.size(); i++) check("stall byte", 32'(got[i]), 32'(exp_b[i]));
    tx_ready = 1'b1;
    tick();

    // Second alu_done 5 cycles after the first is dropped
    calc_res = 32'h0000_007B;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    repeat (4) tick();
    calc_res = 32'd999;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("drop pulse", 32'(drop), 32'd1);
    tick();
    check("drop single", 32'(drop), 32'd0);
    cyc = 6;
    while (!tx_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("drop latency", 32'(cyc), 32'd33);
    for (int i = 0; i < 3; i++) begin
      check("drop byte", 32'({tx_valid, tx_data}), 32'({1'b1, ch(vecs[0], i)}));
      tick();
    end
    check_term("drop", 1'b0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid || busy) cnt++;
      tick();
    end
    check("drop no 2nd result", 32'(cnt), 32'd0);

    // Reset after two bytes of 12345, with alu_done asserted alongside reset
    calc_res = 32'd12345;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check("rst first byte", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h31}));
    tick();
    check("rst second byte", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h32}));
    tick();
    n_rst = 1'b1;
    alu_done = 1'b1;
    calc_res = 32'd7;
    tick();
    check("rst abort", 32'({tx_valid, tx_data, busy, drop}), 32'd0);
    n_rst = 1'b0;
    alu_done = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid || busy) cnt++;
      tick();
    end
    check("rst quiet", 32'(cnt), 32'd0);
    run_vec(vecs[0], "post-rst", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/res_formatter.md
RES_FORMATTER -- requirements
Module: res_formatter

Interface
REQ-001 The block SHALL have parameter RES_W, default 32, meaning the width of the ALU result in bits; only 32 is supported.
REQ-002 The block SHALL have parameter DIG_N, default 10, meaning the number of BCD digits, which must hold 2^31.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port n_rst, input, 1 bit: reset, which is synchronous and active-high (asserted when 1).
REQ-005 Port alu_done, input, 1 bit: single-cycle pulse marking calc_res valid.
REQ-006 Port calc_res, input, 32 bits: signed two's-complement result.
REQ-007 Port tx_data, output, 8 bits: ASCII byte toward the UART transmitter.
REQ-008 Port tx_valid, output, 1 bit: tx_data holds a byte to send.
REQ-009 Port tx_ready, input, 1 bit: the UART accepts a byte this cycle.
REQ-010 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port drop, output, 1 bit: one-cycle pulse when alu_done arrives while busy.

Function
REQ-012 The state machine SHALL have exactly these states: IDLE, CONV, SIGN, DIGIT, CR, LF.
REQ-013 IDLE -> CONV when alu_done=1; on that same edge the block SHALL capture the sign and the 32-bit unsigned magnitude.
REQ-014 Magnitude rule: for a negative input the magnitude is -calc_res taken as unsigned; 0x80000000 yields 2147483648 with no overflow.
REQ-015 CONV SHALL run iterative shift-add-3 (double dabble) for exactly 32 cycles into DIG_N BCD digits.
REQ-016 On leaving CONV the block SHALL go to SIGN if the input was negative, otherwise to DIGIT.
REQ-017 The first tx_valid SHALL rise exactly 33 cycles after the capture edge.
REQ-018 SIGN SHALL emit 0x2D ('-').
REQ-019 DIGIT SHALL emit the digits most-significant first as 0x30+digit.
REQ-020 DIGIT SHALL skip leading zeros but always emit at least one digit, so a zero result sends "0".
REQ-021 After the last digit the block SHALL go to CR if FMT_CRLF_EN is defined, otherwise to LF.
REQ-022 CR SHALL emit 0x0D; LF SHALL emit 0x0A; after LF is accepted the block SHALL return to IDLE.
REQ-023 Handshake: a byte transfers on a rising edge with tx_valid=1 and tx_ready=1; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-024 tx_valid SHALL never drop before the byte is accepted.
REQ-025 Back-to-back: after each accepted byte, the next byte SHALL be presented in the following cycle, sustaining 1 byte/cycle while tx_ready=1.
REQ-026 tx_valid SHALL be 0 in IDLE and CONV.
REQ-027 An alu_done while busy SHALL be ignored (no capture) and SHALL pulse drop=1 for one cycle.
REQ-028 An alu_done in the same cycle that LF is accepted SHALL be dropped, because the state is still LF during that cycle.
REQ-029 The byte count per result SHALL be (sign) + digits (1..10) + terminator (1 or 2), i.e. at most 13 bytes.

Reset
REQ-030 n_rst=1 SHALL force, on the next edge, state=IDLE, tx_valid=0, tx_data=0x00, busy=0, drop=0, and clear the BCD/shift registers.
REQ-031 Reset mid-conversion or mid-stream SHALL abort the current result with no further bytes emitted; reset SHALL take priority over alu_done.

Configuration
REQ-032 With macro FMT_CRLF_EN defined, each result SHALL be terminated with 0x0D 0x0A.
REQ-033 With FMT_CRLF_EN undefined, each result SHALL be terminated with 0x0A only, the CR state SHALL be unreachable, and REQ-017 latency is unchanged.

Structure
REQ-034 Shared package calc_fmt_pkg SHALL hold the state enum and the ASCII constants (0x2D, 0x30, 0x0D, 0x0A).
REQ-035 Sub-module bin2bcd SHALL be used: iterative 32-cycle double dabble with start/done/bcd[39:0] ports, instantiated once.

Verification
REQ-036 Scenario: calc_res=0x0000007B, tx_ready=1 -> bytes "123" then CR LF (if FMT_CRLF_EN defined); first tx_valid 33 cycles after capture.
REQ-037 Scenario: calc_res=0x80000000 -> bytes "-2147483648" then terminator; 11 characters before the terminator.
REQ-038 Scenario: calc_res=0 -> single 0x30 then terminator.
REQ-039 Scenario: calc_res=0xFFFFFFFF, tx_ready toggling 0/1 every cycle -> "-1" then terminator; tx_data is stable during each stall; no byte is duplicated or lost.
REQ-040 Scenario: a second alu_done 5 cycles after the first -> drop pulses once; only the first result is emitted.
REQ-041 Scenario: n_rst=1 during DIGIT after 2 bytes -> tx_valid=0 next cycle and state IDLE; a new alu_done afterward formats correctly.
